// File: rtl/regfile_mp_init.sv
// Parametrised NR-read / NW-write register file with a reset-triggered init sweep.
// Optional macro REGFILE_MP_BYPASS_EN enables write-first forwarding to the read ports.
module regfile_mp_init #(
   parameter int unsigned   AW       = 5,
   parameter int unsigned   DW       = 64,
   parameter int unsigned   LO       = 0,
   parameter int unsigned   HI       = 31,
   parameter int unsigned   NR       = 5,
   parameter int unsigned   NW       = 2,
   parameter logic [DW-1:0] INIT_VAL = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [NW-1:0]    WE,
   input  logic [NW*AW-1:0] ADDR_IN,
   input  logic [NW*DW-1:0] D_IN,
   input  logic [NR*AW-1:0] ADDR_R,
   output logic [NR*DW-1:0] D_OUT,
   output logic             INIT_BUSY,
   output logic             ADDR_ERR
);

   // One extra bit so the sweep counter cannot wrap when HI = 2^AW-1.
   localparam int unsigned CW = AW + 1;

   typedef enum logic {StInit, StReady} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic [DW-1:0] mem_q [LO:HI];

   logic [NW-1:0] wr_ok;
   logic [NW-1:0] wr_bad;
   logic [NR-1:0] rd_bad;

   // Unsigned wrap makes addresses below LO land above HI-LO.
   function automatic logic in_range(input logic [AW-1:0] a);
      return (32'(a) - LO) <= (HI - LO);
   endfunction

   always_comb begin
      wr_ok  = '0;
      wr_bad = '0;
      rd_bad = '0;
      for (int w = 0; w < NW; w++) begin
         wr_ok[w]  = WE[w] && in_range(ADDR_IN[w*AW +: AW]);
         wr_bad[w] = WE[w] && !in_range(ADDR_IN[w*AW +: AW]);
      end
      for (int r = 0; r < NR; r++) begin
         rd_bad[r] = !in_range(ADDR_R[r*AW +: AW]);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StInit;
         cnt_q   <= CW'(LO);
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         StInit: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(HI)) state_d = StReady;
         end
         StReady: begin
            if ((|wr_bad) || (|rd_bad)) err_d = 1'b1;
         end
         default: state_d = StInit;
      endcase
   end

   // Ascending port order lets the highest-index port win a same-address conflict.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         for (int unsigned e = LO; e <= HI; e++) begin
            if (state_q == StInit) begin
               if (cnt_q == CW'(e)) mem_q[e] <= INIT_VAL;
            end else begin
               for (int w = 0; w < NW; w++) begin
                  if (wr_ok[w] && (ADDR_IN[w*AW +: AW] == AW'(e))) begin
                     mem_q[e] <= D_IN[w*DW +: DW];
                  end
               end
            end
         end
      end
   end

   always_comb begin
      D_OUT = '0;
      for (int r = 0; r < NR; r++) begin
         if (state_q == StInit) begin
            D_OUT[r*DW +: DW] = INIT_VAL;
         end else if (!rd_bad[r]) begin
            for (int unsigned e = LO; e <= HI; e++) begin
               if (ADDR_R[r*AW +: AW] == AW'(e)) D_OUT[r*DW +: DW] = mem_q[e];
            end
`ifdef REGFILE_MP_BYPASS_EN
            for (int w = 0; w < NW; w++) begin
               if (wr_ok[w] && (ADDR_IN[w*AW +: AW] == ADDR_R[r*AW +: AW])) begin
                  D_OUT[r*DW +: DW] = D_IN[w*DW +: DW];
               end
            end
`else
`endif
         end
      end
   end

   assign INIT_BUSY = (state_q == StInit);
   assign ADDR_ERR  = err_q;

endmodule

// File: tb/tb_regfile_mp_init.sv
// Self-checking bench for regfile_mp_init (LO=0, HI=23) against a behavioural array model.
// Expectations for same-cycle read/write follow REGFILE_MP_BYPASS_EN when defined.
module tb_regfile_mp_init;

   localparam int AW = 5;
   localparam int DW = 64;
   localparam int LO = 0;
   localparam int HI = 23;
   localparam int NR = 5;
   localparam int NW = 2;
   localparam logic [DW-1:0] INIT_VAL = 64'hDEAD;

   logic             CLK = 1'b0;
   logic             RST;
   logic [NW-1:0]    WE;
   logic [NW*AW-1:0] ADDR_IN;
   logic [NW*DW-1:0] D_IN;
   logic [NR*AW-1:0] ADDR_R;
   logic [NR*DW-1:0] D_OUT;
   logic             INIT_BUSY;
   logic             ADDR_ERR;

   always #5 CLK = ~CLK;

   regfile_mp_init #(
      .AW(AW), .DW(DW), .LO(LO), .HI(HI), .NR(NR), .NW(NW), .INIT_VAL(INIT_VAL)
   ) dut (
      .CLK(CLK), .RST(RST), .WE(WE), .ADDR_IN(ADDR_IN), .D_IN(D_IN),
      .ADDR_R(ADDR_R), .D_OUT(D_OUT), .INIT_BUSY(INIT_BUSY), .ADDR_ERR(ADDR_ERR)
   );

   logic [DW-1:0] m_mem [0:31];
   bit            m_busy = 1'b1;
   int            m_left = 0;
   bit            m_err  = 1'b0;
   int            errors = 0;
   int            checks = 0;

   function automatic bit ok_addr(input int a);
      return (a >= LO) && (a <= HI);
   endfunction

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_rd(input int r);
      int            a = int'(ADDR_R[r*AW +: AW]);
      logic [DW-1:0] v;
      if (m_busy) return INIT_VAL;
      if (!ok_addr(a)) return '0;
      v = m_mem[a];
`ifdef REGFILE_MP_BYPASS_EN
      for (int w = 0; w < NW; w++) begin
         if (WE[w] && (int'(ADDR_IN[w*AW +: AW]) == a)) v = D_IN[w*DW +: DW];
      end
`endif
      return v;
   endfunction

   // Sweep modelled as a countdown that fills the whole array when it expires.
   function automatic void model_step();
      if (RST) begin
         m_busy = 1'b1;
         m_left = HI - LO + 1;
         m_err  = 1'b0;
      end else if (m_busy) begin
         m_left--;
         if (m_left == 0) begin
            m_busy = 1'b0;
            for (int a = 0; a < 32; a++) m_mem[a] = INIT_VAL;
         end
      end else begin
         for (int w = 0; w < NW; w++) begin
            if (WE[w]) begin
               if (ok_addr(int'(ADDR_IN[w*AW +: AW]))) m_mem[ADDR_IN[w*AW +: AW]] = D_IN[w*DW +: DW];
               else m_err = 1'b1;
            end
         end
         for (int r = 0; r < NR; r++) begin
            if (!ok_addr(int'(ADDR_R[r*AW +: AW]))) m_err = 1'b1;
         end
      end
   endfunction

   task automatic tick();
      @(negedge CLK);
      chk("init_busy", {63'd0, INIT_BUSY}, {63'd0, m_busy});
      chk("addr_err", {63'd0, ADDR_ERR}, {63'd0, m_err});
      for (int r = 0; r < NR; r++) begin
         chk($sformatf("rd%0d@%0d", r, ADDR_R[r*AW +: AW]), D_OUT[r*DW +: DW], exp_rd(r));
      end
      @(posedge CLK);
      model_step();
      #1;
   endtask

   task automatic set_wr(input int w, input bit en, input int a, input logic [DW-1:0] d);
      WE[w]              = en;
      ADDR_IN[w*AW +: AW] = AW'(a);
      D_IN[w*DW +: DW]   = d;
   endtask

   task automatic set_rd_all(input int a);
      for (int r = 0; r < NR; r++) ADDR_R[r*AW +: AW] = AW'(a);
   endtask

   task automatic rand_inputs(input int max_addr, input int we_pct);
      for (int w = 0; w < NW; w++) begin
         WE[w]               = ($urandom_range(99, 0) < we_pct);
         ADDR_IN[w*AW +: AW] = AW'($urandom_range(max_addr, 0));
         D_IN[w*DW +: DW]    = {$urandom(), $urandom()};
      end
      for (int r = 0; r < NR; r++) ADDR_R[r*AW +: AW] = AW'($urandom_range(max_addr, 0));
   endtask

   initial begin
      RST = 1'b1; WE = '0; ADDR_IN = '0; D_IN = '0; ADDR_R = '0;
      @(posedge CLK);
      model_step();
      #1;
      tick();
      tick();
      RST = 1'b0;

      // Sweep: writes and wild addresses must leave no trace.
      for (int i = 0; i < HI - LO + 1; i++) begin
         rand_inputs(31, 50);
         tick();
      end
      WE = '0;
      for (int a = LO; a <= HI; a++) begin
         set_rd_all(a);
         tick();
      end

      set_wr(0, 1, 5, 64'h11);
      set_wr(1, 1, 9, 64'h22);
      set_rd_all(0);
      tick();
      WE = '0;
      set_rd_all(5);
      tick();
      set_rd_all(9);
      tick();

      set_wr(0, 1, 7, 64'hAA);
      set_wr(1, 1, 7, 64'hBB);
      tick();
      WE = '0;
      set_rd_all(7);
      tick();

      set_wr(0, 1, 3, 64'h55);
      set_rd_all(3);
      tick();
      WE = '0;
      tick();

      set_wr(0, 1, 30, 64'h77);
      tick();
      WE = '0;
      tick();
      set_rd_all(28);
      tick();
      for (int i = 0; i < 20; i++) begin
         rand_inputs(HI, 60);
         tick();
      end
      for (int i = 0; i < 100; i++) begin
         rand_inputs(31, 60);
         tick();
      end

      // Reset at sweep cycle 10 with writes pending, then a full clean sweep.
      rand_inputs(HI, 100);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      for (int i = 0; i < 10; i++) begin
         rand_inputs(31, 80);
         tick();
      end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      for (int i = 0; i < HI - LO + 1; i++) begin
         rand_inputs(31, 80);
         tick();
      end
      WE = '0;
      for (int a = LO; a <= HI; a++) begin
         set_rd_all(a);
         tick();
      end

      // Dense in-range traffic on a narrow window to force conflicts and read/write overlap.
      for (int i = 0; i < 300; i++) begin
         rand_inputs((i % 2 == 0) ? 7 : HI, 70);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
